// File: rtl/max_sub.sv
// Softmax pre-exponent stage: buffers one score vector, tracks its max, then streams max - x_i.
// Optional MAX_SUB_BACKPRESSURE_EN adds max_sub_ready_i so the downstream stage can stall the output.
module max_sub #(
  parameter int data_size  = 32,
  parameter int vector_len = 16,
  parameter int addr_width = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [data_size-1:0]  max_sub_data_i,
  input  logic                  max_sub_data_valid_i,
  input  logic                  max_sub_data_last_i,
`ifdef MAX_SUB_BACKPRESSURE_EN
  input  logic                  max_sub_ready_i,
`endif
  output logic                  max_sub_ready_o,
  output logic [data_size-1:0]  max_sub_data_o,
  output logic                  max_sub_data_valid_o,
  output logic                  max_sub_data_last_o,
  output logic [addr_width:0]   max_sub_count_o
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] SUB  = 1'b1;

  localparam logic [addr_width:0]  CNT_ONE  = (addr_width+1)'(1);
  localparam logic [addr_width:0]  CNT_FULL = (addr_width+1)'(vector_len - 1);
  localparam logic [addr_width-1:0] IDX_ONE = addr_width'(1);
  localparam logic [data_size-1:0] SAT      = {1'b0, {(data_size-1){1'b1}}};

  typedef struct packed {
    logic [data_size-1:0] data;
    logic                 valid;
    logic                 last;
  } out_t;

  logic [0:0]                   state;
  logic [addr_width:0]          count;
  logic [addr_width:0]          count_q;
  logic [addr_width-1:0]        index;
  logic signed [data_size-1:0]  max_q;
  logic [data_size-1:0]         mem [vector_len];
  out_t                         out_q;

  logic                         accept;
  logic                         end_in;
  logic signed [data_size-1:0]  elem;
  logic signed [data_size-1:0]  max_next;
  logic [data_size-1:0]         x;
  logic [data_size:0]           diff;
  logic [data_size-1:0]         diff_sat;
  logic                         is_last_out;

  assign max_sub_ready_o = (state == LOAD);
  assign accept          = max_sub_data_valid_i && max_sub_ready_o;
  assign end_in          = accept && (max_sub_data_last_i || (count == CNT_FULL));
  assign elem            = $signed(max_sub_data_i);
  // first element seeds the max directly, so no negative sentinel is needed
  assign max_next        = ((count == '0) || (elem > max_q)) ? elem : max_q;

  assign x           = mem[index];
  assign diff        = {max_q[data_size-1], max_q} - {x[data_size-1], x};
  // diff is non-negative by construction; the sign bit only guards against misuse
  assign diff_sat    = diff[data_size]   ? '0  :
                       diff[data_size-1] ? SAT : diff[data_size-1:0];
  assign is_last_out = ({1'b0, index} == (count - CNT_ONE));

  assign max_sub_data_o       = out_q.data;
  assign max_sub_data_valid_o = out_q.valid;
  assign max_sub_data_last_o  = out_q.last;
  assign max_sub_count_o      = count_q;

  // buffer holds no reset: stale contents are never read before being rewritten
  always_ff @(posedge clock_i) begin
    if (accept) mem[count[addr_width-1:0]] <= max_sub_data_i;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= LOAD;
      count   <= '0;
      count_q <= '0;
      index   <= '0;
      max_q   <= '0;
      out_q   <= '0;
    end else if (state == LOAD) begin
      out_q.valid <= 1'b0;
      out_q.last  <= 1'b0;
      if (accept) begin
        count <= count + CNT_ONE;
        max_q <= max_next;
        if (end_in) begin
          state   <= SUB;
          count_q <= count + CNT_ONE;
        end
      end
    end else begin
`ifdef MAX_SUB_BACKPRESSURE_EN
      if (out_q.valid && out_q.last && max_sub_ready_i) begin
        state       <= LOAD;
        count       <= '0;
        index       <= '0;
        out_q.valid <= 1'b0;
        out_q.last  <= 1'b0;
      end else if (!out_q.valid || max_sub_ready_i) begin
        out_q.data  <= diff_sat;
        out_q.valid <= 1'b1;
        out_q.last  <= is_last_out;
        index       <= index + IDX_ONE;
      end
`else
      out_q.data  <= diff_sat;
      out_q.valid <= 1'b1;
      out_q.last  <= is_last_out;
      index       <= index + IDX_ONE;
      if (is_last_out) begin
        state <= LOAD;
        count <= '0;
        index <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_max_sub.sv
// Randomized self-checking bench for max_sub against a plain-arithmetic softmax max-subtract model.
module tb_max_sub;
`ifdef MAX_SUB_BACKPRESSURE_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_in = '0;
  logic        v_in = 1'b0;
  logic        l_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rdy_out;
  logic [31:0] d_out;
  logic        v_out;
  logic        l_out;
  logic [4:0]  cnt_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] in_q[$];

  max_sub dut (
    .clock_i              (clk),
    .reset_n_i            (rst_n),
    .max_sub_data_i       (d_in),
    .max_sub_data_valid_i (v_in),
    .max_sub_data_last_i  (l_in),
`ifdef MAX_SUB_BACKPRESSURE_EN
    .max_sub_ready_i      (rdy_in),
`endif
    .max_sub_ready_o      (rdy_out),
    .max_sub_data_o       (d_out),
    .max_sub_data_valid_o (v_out),
    .max_sub_data_last_o  (l_out),
    .max_sub_count_o      (cnt_out)
  );

  always #5 clk = ~clk;

  function automatic longint ref_max();
    longint best = longint'($signed(in_q[0]));
    foreach (in_q[i]) if (longint'($signed(in_q[i])) > best) best = longint'($signed(in_q[i]));
    return best;
  endfunction

  function automatic logic [31:0] ref_diff(input logic [31:0] v, input longint m);
    longint d = m - longint'($signed(v));
    if (d > 64'sd2147483647) return 32'h7FFF_FFFF;
    return d[31:0];
  endfunction

  task automatic send_vec(input bit use_last);
    int w;
    for (int i = 0; i < in_q.size(); i++) begin
      d_in = in_q[i];
      v_in = 1'b1;
      l_in = use_last && (i == in_q.size() - 1);
      w = 0;
      @(negedge clk);
      while (!rdy_out && w < 100) begin @(negedge clk); w++; end
      if (!rdy_out) begin
        checks++; errors++;
        $display("FAIL send_timeout: ready stayed %0b, required 1", rdy_out);
        v_in = 1'b0; l_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    v_in = 1'b0;
    l_in = 1'b0;
  endtask

  // Sends in_q, then collects and checks the streamed differences; stall_at/stall_len drive ready_i.
  task automatic run_vector(input string name, input bit use_last, input int stall_at, input int stall_len);
    int n, k, cyc, first_lat, stalls;
    bit done, prev_stall, rdy;
    logic [31:0] prev_d, exp_d;
    logic prev_l;
    longint m;
    n = in_q.size();
    m = ref_max();
    rdy_in = 1'b1;
    send_vec(use_last);
    checks++;
    if (v_out !== 1'b0 || rdy_out !== 1'b0 || cnt_out !== 5'(n)) begin
      errors++;
      $display("FAIL %s_after_load: valid=%0b ready=%0b count=%0d, required 0 0 %0d", name, v_out, rdy_out, cnt_out, n);
    end
    k = 0; cyc = 0; first_lat = -1; stalls = 0; done = 0; prev_stall = 0;
    prev_d = '0; prev_l = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      v_in = 1'b0;
      if (prev_stall) begin
        checks++;
        if (v_out !== 1'b1 || d_out !== prev_d || l_out !== prev_l) begin
          errors++;
          $display("FAIL %s_hold: got %0b %h %0b, required 1 %h %0b", name, v_out, d_out, l_out, prev_d, prev_l);
        end
      end
      rdy = 1'b1;
      if (v_out === 1'b1) begin
        if (first_lat < 0) first_lat = cyc;
        if (BP && k == stall_at && stalls < stall_len) begin rdy = 1'b0; stalls++; end
        if (rdy) begin
          exp_d = (k < n) ? ref_diff(in_q[k], m) : 32'hDEAD_BEEF;
          checks++;
          if (d_out !== exp_d || l_out !== (k == n - 1) || rdy_out !== (!BP && k == n - 1) || cnt_out !== 5'(n)) begin
            errors++;
            $display("FAIL %s_out[%0d]: data=%h last=%0b ready=%0b count=%0d, required %h %0b %0b %0d",
                     name, k, d_out, l_out, rdy_out, cnt_out, exp_d, (k == n - 1), (!BP && k == n - 1), n);
          end
          if (l_out === 1'b1) done = 1;
          k++;
        end
        prev_d = d_out; prev_l = l_out;
      end
      prev_stall = !rdy;
      rdy_in = rdy;
    end
    checks++;
    if (!done || k != n || first_lat != 1) begin
      errors++;
      $display("FAIL %s_stream: outputs=%0d first_latency=%0d done=%0b, required %0d 1 1", name, k, first_lat, done, n);
    end
    rdy_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (v_out !== 1'b0 || l_out !== 1'b0 || rdy_out !== 1'b1) begin
      errors++;
      $display("FAIL %s_drop: valid=%0b last=%0b ready=%0b, required 0 0 1", name, v_out, l_out, rdy_out);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (rdy_out !== 1'b1 || v_out !== 1'b0 || l_out !== 1'b0 || d_out !== 32'h0 || cnt_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b valid=%0b last=%0b data=%h count=%0d, required 1 0 0 0 0",
               rdy_out, v_out, l_out, d_out, cnt_out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_three();
    in_q = '{32'h0001_0000, 32'h0003_0000, 32'hFFFF_0000};
    rdy_in = 1'b1;
    send_vec(1'b1);
    // junk offered while the block is streaming must be ignored
    d_in = 32'h7777_7777; v_in = 1'b1;
    checks++;
    if (cnt_out !== 5'd3 || v_out !== 1'b0 || rdy_out !== 1'b0) begin
      errors++;
      $display("FAIL three_load: count=%0d valid=%0b ready=%0b, required 3 0 0", cnt_out, v_out, rdy_out);
    end
    @(posedge clk); #1; v_in = 1'b0;
    checks++;
    if (v_out !== 1'b1 || d_out !== 32'h0002_0000 || l_out !== 1'b0) begin
      errors++;
      $display("FAIL three_out0: valid=%0b data=%h last=%0b, required 1 00020000 0", v_out, d_out, l_out);
    end
    @(posedge clk); #1;
    checks++;
    if (v_out !== 1'b1 || d_out !== 32'h0000_0000 || l_out !== 1'b0) begin
      errors++;
      $display("FAIL three_out1: valid=%0b data=%h last=%0b, required 1 00000000 0", v_out, d_out, l_out);
    end
    @(posedge clk); #1;
    checks++;
    if (v_out !== 1'b1 || d_out !== 32'h0004_0000 || l_out !== 1'b1) begin
      errors++;
      $display("FAIL three_out2: valid=%0b data=%h last=%0b, required 1 00040000 1", v_out, d_out, l_out);
    end
    if (BP) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    checks++;
    if (v_out !== 1'b0 || rdy_out !== 1'b1) begin
      errors++;
      $display("FAIL three_drop: valid=%0b ready=%0b, required 0 1", v_out, rdy_out);
    end
  endtask

  task automatic test_single();
    in_q = '{32'h1234_5678};
    run_vector("single", 1'b1, 99, 0);
  endtask

  task automatic test_forced_end();
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back(32'(i) << 16);
    run_vector("forced", 1'b0, 99, 0);
  endtask

  task automatic test_saturation();
    in_q = '{32'h7FFF_FFFF, 32'h8000_0000};
    run_vector("saturate", 1'b1, 99, 0);
  endtask

  task automatic test_ties();
    in_q = '{32'hFFFB_0000, 32'hFFFD_0000, 32'hFFFD_0000};
    run_vector("ties_neg", 1'b1, 99, 0);
  endtask

  task automatic test_reset_mid_sub();
    in_q = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000};
    send_vec(1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (v_out !== 1'b1 || d_out !== 32'h0003_0000) begin
      errors++;
      $display("FAIL midreset_pre: valid=%0b data=%h, required 1 00030000", v_out, d_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (v_out !== 1'b0 || l_out !== 1'b0 || rdy_out !== 1'b1 || cnt_out !== 5'd0) begin
      errors++;
      $display("FAIL midreset_async: valid=%0b last=%0b ready=%0b count=%0d, required 0 0 1 0", v_out, l_out, rdy_out, cnt_out);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (v_out !== 1'b0 || rdy_out !== 1'b1) begin
        errors++;
        $display("FAIL midreset_quiet[%0d]: valid=%0b ready=%0b, required 0 1", i, v_out, rdy_out);
      end
    end
    in_q = '{32'h0002_0000, 32'h0005_0000};
    run_vector("after_reset", 1'b1, 99, 0);
  endtask

  task automatic test_backpressure();
    in_q = '{32'h0001_0000, 32'h0009_0000, 32'hFFF0_0000, 32'h0004_0000};
    run_vector("stall", 1'b1, 1, 3);
  endtask

  task automatic test_random();
    int len;
    bit forced;
    for (int v = 0; v < 14; v++) begin
      len = $urandom_range(1, 16);
      forced = (len == 16) && ($urandom_range(0, 1) == 1);
      in_q.delete();
      for (int i = 0; i < len; i++) begin
        if (v % 3 == 0) in_q.push_back($urandom());
        else in_q.push_back(32'($signed($urandom_range(0, 4000)) - 2000) << 10);
      end
      run_vector("random", !forced, $urandom_range(0, 15), $urandom_range(0, 4));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_three();
    test_single();
    test_forced_end();
    test_saturation();
    test_ties();
    test_reset_mid_sub();
    if (BP) test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
